// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   OP_ADD/OP_SUB/OP_INC/OP_DEC : in_op encodings
//   state_e                     : control FSM states
//   width_ok()                  : legality check for the WIDTH parameter
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // WIDTH must be a whole number of nibbles and at least one nibble.
  function automatic bit width_ok(int unsigned w);
    return (w >= 4) && ((w % 4) == 0);
  endfunction

endpackage

// File: rtl/addsub_nibble.sv
// 4-bit ripple-carry adder slice used once per cycle by nibble_serial_alu.
// Subtraction is handled upstream by feeding the inverted operand and cin=1.
// Optional feature macro: ALU_OVF_FLAG_EN adds the c3 output.
// Ports:
//   a, b  in   4  addends
//   cin   in   1  carry into bit 0
//   s     out  4  sum
//   cout  out  1  carry out of bit 3
//   c3    out  1  carry into bit 3 (only with ALU_OVF_FLAG_EN)
module addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
`ifdef ALU_OVF_FLAG_EN
  output logic       c3,
`endif
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];
`ifdef ALU_OVF_FLAG_EN
  assign c3   = c[3];
`endif

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-cycle WIDTH-bit add/subtract unit. One 4-bit slice processes one nibble per
// cycle, LSB first; the carry is registered between cycles. Requests arrive over an
// in_valid/in_ready handshake, results leave over out_valid/out_ready.
// Optional feature macro: ALU_OVF_FLAG_EN adds the out_ovf signed-overflow flag.
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      request can be accepted (idle, not in reset)
//   in_op      in   2      00 ADD, 01 SUB, 10 INC, 11 DEC
//   in_x       in   WIDTH  operand x
//   in_y       in   WIDTH  operand y (ignored for INC/DEC)
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      downstream accepts result
//   out_s      out  WIDTH  result
//   out_cout   out  1      carry out of MSB (1 = no borrow for SUB/DEC)
//   out_zero   out  1      out_s == 0
//   out_ovf    out  1      signed overflow (only with ALU_OVF_FLAG_EN)
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
`ifdef ALU_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic             out_zero
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CNTW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NIB - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("nibble_serial_alu: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;     // effective y: already inverted / substituted
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
`ifdef ALU_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
  logic             slice_c3;
`endif

  logic [3:0]       slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next;

  // Operands shift right each cycle so the slice always sees bits [3:0].
  addsub_nibble u_slice (
    .a    (x_q[3:0]),
    .b    (y_q[3:0]),
    .cin  (carry_q),
    .s    (slice_s),
`ifdef ALU_OVF_FLAG_EN
    .c3   (slice_c3),
`endif
    .cout (slice_cout)
  );

  // Result fills from the top; after NIB shifts the first nibble lands in [3:0].
  if (WIDTH == 4) begin : g_res_one
    assign res_next = slice_s;
  end else begin : g_res_many
    assign res_next = {slice_s, res_q[WIDTH-1:4]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
`ifdef ALU_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          cnt_d   = '0;
          state_d = ST_BUSY;
          unique case (in_op)
            OP_ADD: begin y_d = in_y;  carry_d = 1'b0; end
            OP_SUB: begin y_d = ~in_y; carry_d = 1'b1; end
            OP_INC: begin y_d = '0;    carry_d = 1'b1; end
            OP_DEC: begin y_d = '1;    carry_d = 1'b0; end
          endcase
        end
      end
      ST_BUSY: begin
        x_d     = x_q >> 4;
        y_d     = y_q >> 4;
        res_d   = res_next;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = slice_cout;
          zero_d  = (res_next == '0);
`ifdef ALU_OVF_FLAG_EN
          ovf_d   = slice_c3 ^ slice_cout;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
`ifdef ALU_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign out_s     = res_q;
  assign out_cout  = cout_q;
  assign out_zero  = zero_q;
`ifdef ALU_OVF_FLAG_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Self-checking bench for nibble_serial_alu: directed corner cases plus random
// operations on a WIDTH=16 instance and a WIDTH=4 instance, compared against an
// integer-arithmetic reference model. Honours ALU_OVF_FLAG_EN.
module tb_nibble_serial_alu;

  localparam logic [1:0] T_ADD = 2'b00;
  localparam logic [1:0] T_SUB = 2'b01;
  localparam logic [1:0] T_INC = 2'b10;
  localparam logic [1:0] T_DEC = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_cout, out_zero, out_ovf;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_x = '0, in_y = '0, out_s;

  logic        d4_in_valid = 1'b0, d4_out_ready = 1'b0;
  logic        d4_in_ready, d4_out_valid, d4_out_cout, d4_out_zero, d4_out_ovf;
  logic [1:0]  d4_in_op = 2'b00;
  logic [3:0]  d4_in_x = '0, d4_in_y = '0, d4_out_s;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_alu #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
`ifdef ALU_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .out_zero  (out_zero)
  );

  nibble_serial_alu #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (d4_in_valid),
    .in_ready  (d4_in_ready),
    .in_op     (d4_in_op),
    .in_x      (d4_in_x),
    .in_y      (d4_in_y),
    .out_valid (d4_out_valid),
    .out_ready (d4_out_ready),
    .out_s     (d4_out_s),
    .out_cout  (d4_out_cout),
`ifdef ALU_OVF_FLAG_EN
    .out_ovf   (d4_out_ovf),
`endif
    .out_zero  (d4_out_zero)
  );

`ifndef ALU_OVF_FLAG_EN
  assign out_ovf    = 1'b0;
  assign d4_out_ovf = 1'b0;
`endif

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic on integers, signed overflow from the
  // mathematically exact signed result.
  function automatic void model(input int w, input logic [1:0] op, input longint x,
                                input longint y, output longint s, output bit co,
                                output bit z, output bit ov);
    longint m, half, b, full, sx, sb, r;
    bit     sub;
    m    = longint'(1) << w;
    half = m / 2;
    b    = (op == T_INC || op == T_DEC) ? 1 : y;
    sub  = (op == T_SUB || op == T_DEC);
    full = sub ? (x + m - b) : (x + b);
    co   = (full >= m);
    s    = full % m;
    z    = (s == 0);
    sx   = (x >= half) ? x - m : x;
    sb   = (b >= half) ? b - m : b;
    r    = sub ? sx - sb : sx + sb;
    ov   = (r < -half) || (r >= half);
  endfunction

  // One operation on the 16-bit unit; hold keeps out_ready low that many cycles in
  // DONE, poke pulses in_valid during the hold.
  task automatic run16(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input int hold, input bit poke);
    longint es;
    bit     ec, ez, eo;
    int     n;
    model(16, op, longint'(x), longint'(y), es, ec, ez, eo);
    in_op = op; in_x = x; in_y = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0; in_x = 16'($urandom); in_y = 16'($urandom); in_op = 2'($urandom);
    n = 1;  // the accepting cycle counts as the first
    while (!out_valid && n < 50) begin step(); n++; end
    check("out_valid", longint'(out_valid), 1);
    check("latency", longint'(n), 5);
    check("s", longint'(out_s), es);
    check("cout", longint'(out_cout), longint'(ec));
    check("zero", longint'(out_zero), longint'(ez));
`ifdef ALU_OVF_FLAG_EN
    check("ovf", longint'(out_ovf), longint'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = poke && (i == 2);
      step();
      check("hold_valid", longint'(out_valid), 1);
      check("hold_ready", longint'(in_ready), 0);
      check("hold_s", longint'(out_s), es);
      check("hold_cout", longint'(out_cout), longint'(ec));
      check("hold_zero", longint'(out_zero), longint'(ez));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_valid", longint'(out_valid), 0);
    check("drain_ready", longint'(in_ready), 1);
  endtask

  task automatic run4(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
    longint es;
    bit     ec, ez, eo;
    int     n;
    model(4, op, longint'(x), longint'(y), es, ec, ez, eo);
    d4_in_op = op; d4_in_x = x; d4_in_y = y; d4_in_valid = 1'b1;
    n = 0;
    while (!d4_in_ready && n < 50) begin step(); n++; end
    if (!d4_in_ready) check("w4_accept_timeout", 0, 1);
    step();
    d4_in_valid = 1'b0; d4_in_x = 4'($urandom); d4_in_y = 4'($urandom);
    n = 1;
    while (!d4_out_valid && n < 50) begin step(); n++; end
    check("w4_latency", longint'(n), 2);
    check("w4_s", longint'(d4_out_s), es);
    check("w4_cout", longint'(d4_out_cout), longint'(ec));
    check("w4_zero", longint'(d4_out_zero), longint'(ez));
`ifdef ALU_OVF_FLAG_EN
    check("w4_ovf", longint'(d4_out_ovf), longint'(eo));
`endif
    d4_out_ready = 1'b1;
    step();
    d4_out_ready = 1'b0;
    check("w4_drain_valid", longint'(d4_out_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx, ry;
    reset = 1'b1;
    step(); step();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_s", longint'(out_s), 0);
    check("rst_cout", longint'(out_cout), 0);
    check("rst_zero", longint'(out_zero), 0);
`ifdef ALU_OVF_FLAG_EN
    check("rst_ovf", longint'(out_ovf), 0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_ready", longint'(in_ready), 1);

    // Directed corner cases.
    run16(T_ADD, 16'h1234, 16'h0FFF, 0, 1'b0);
    run16(T_SUB, 16'h0005, 16'h0005, 0, 1'b0);
    run16(T_SUB, 16'h0000, 16'h0001, 0, 1'b0);
    run16(T_INC, 16'hFFFF, 16'h1234, 0, 1'b0);
    run16(T_DEC, 16'h0000, 16'h5555, 0, 1'b0);
    run16(T_ADD, 16'h7FFF, 16'h0001, 0, 1'b0);
    run16(T_SUB, 16'h8000, 16'h0001, 0, 1'b0);
    run16(T_ADD, 16'h0001, 16'h0001, 0, 1'b0);
    // Back-pressure in DONE with a stray request that must be ignored.
    run16(T_ADD, 16'hA5A5, 16'h1111, 6, 1'b1);

    // Reset while BUSY with cnt=1 discards the operation.
    in_op = T_ADD; in_x = 16'h1234; in_y = 16'h0001; in_valid = 1'b1;
    step();              // accept edge
    in_valid = 1'b0;
    step();              // first nibble done, cnt=1
    reset = 1'b1;
    #1;
    check("midrst_in_ready", longint'(in_ready), 0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_s", longint'(out_s), 0);
    check("midrst_ready", longint'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("midrst_no_pulse", longint'(out_valid), 0);
    end
    run16(T_ADD, 16'h0001, 16'h0001, 0, 1'b0);

    // Random operations with occasional corner operands and back-pressure.
    for (int i = 0; i < 60; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rx = 16'hFFFF;
        1: rx = 16'h0000;
        2: ry = rx;
        3: rx = 16'h8000;
        default: ;
      endcase
      run16(2'($urandom), rx, ry, $urandom_range(0, 3), 1'($urandom));
    end

    // WIDTH=4 instance.
    run4(T_ADD, 4'h9, 4'h8);
    run4(T_SUB, 4'h3, 4'h3);
    run4(T_DEC, 4'h0, 4'h0);
    run4(T_INC, 4'h7, 4'h0);
    for (int i = 0; i < 20; i++) run4(2'($urandom), 4'($urandom), 4'($urandom));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
